// File: rtl/regfile_writeback_pkg.sv
// rtl/regfile_writeback_pkg.sv - shared types and defaults for the writeback stage
package regfile_writeback_pkg;

  localparam int DEF_DATA_W       = 32;
  localparam int DEF_ADDR_W       = 5;
  localparam int DEF_FIFO_DEPTH   = 2;
  localparam int DEF_STARVE_LIMIT = 8;

  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LD,
    SRC_MD
  } wb_src_e;

  // Pointer width that stays legal for a single-entry buffer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// rtl/regfile_writeback_if.sv - producer, issue and register-file signals of the writeback stage
interface regfile_writeback_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  logic                  alu_valid;
  logic [ADDR_W-1:0]     alu_reg;
  logic [DATA_W-1:0]     alu_data;

  logic                  ld_valid;
  logic                  ld_ready;
  logic [ADDR_W-1:0]     ld_reg;
  logic [DATA_W-1:0]     ld_data;

  logic                  md_valid;
  logic                  md_ready;
  logic [ADDR_W-1:0]     md_reg;
  logic [DATA_W-1:0]     md_data;

  logic                  issue_valid;
  logic [ADDR_W-1:0]     issue_reg;

  logic                  reg_write;
  logic [ADDR_W-1:0]     write_reg;
  logic [DATA_W-1:0]     write_data;
  logic [2**ADDR_W-1:0]  pending;
  logic                  wb_stall;
  logic                  drop_err;

  modport master (
    output alu_valid, alu_reg, alu_data,
    output ld_valid, ld_reg, ld_data,
    output md_valid, md_reg, md_data,
    output issue_valid, issue_reg,
    input  ld_ready, md_ready,
    input  reg_write, write_reg, write_data, pending, wb_stall, drop_err
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  ld_valid, ld_reg, ld_data,
    input  md_valid, md_reg, md_data,
    input  issue_valid, issue_reg,
    output ld_ready, md_ready,
    output reg_write, write_reg, write_data, pending, wb_stall, drop_err
  );

endinterface

// File: rtl/regfile_writeback_wb_fifo.sv
// rtl/regfile_writeback_wb_fifo.sv - small circular buffer holding mul/div results
module wb_fifo
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    // Occupancy only moves when exactly one side is active.
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register file write port owner: arbiter, starve guard, scoreboard
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                clk,
  input  logic                reset,
  regfile_writeback_if.slave  bus
);

  localparam int NREG  = 2**ADDR_W;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENT_W-1:0] fifo_head;

  wb_src_e           win;
  logic [ADDR_W-1:0] win_reg;
  logic [DATA_W-1:0] win_data;

  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic              wb_stall_q, wb_stall_d;
  logic              drop_err_q, drop_err_d;
  logic [CNT_W-1:0]  starve_q, starve_d;

  assign fifo_push = bus.md_valid && !fifo_full;
  assign fifo_pop  = (win == SRC_MD);

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({bus.md_reg, bus.md_data}),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // During a forced slot only the buffered mul/div result may write.
  always_comb begin
    win      = SRC_NONE;
    win_reg  = '0;
    win_data = '0;
    if (wb_stall_q) begin
      if (!fifo_empty) win = SRC_MD;
    end else if (bus.alu_valid) begin
      win = SRC_ALU;
    end else if (bus.ld_valid) begin
      win = SRC_LD;
    end else if (!fifo_empty) begin
      win = SRC_MD;
    end
    case (win)
      SRC_ALU: begin win_reg = bus.alu_reg; win_data = bus.alu_data; end
      SRC_LD:  begin win_reg = bus.ld_reg;  win_data = bus.ld_data;  end
      SRC_MD:  begin win_reg = fifo_head[ENT_W-1:DATA_W]; win_data = fifo_head[DATA_W-1:0]; end
      default: begin win_reg = '0; win_data = '0; end
    endcase
  end

  always_comb begin
    reg_write_d  = (win != SRC_NONE) && (win_reg != ADDR_W'(REG_ZERO));
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (win != SRC_NONE) begin
      write_reg_d  = win_reg;
      write_data_d = win_data;
    end

    wb_stall_d = 1'b0;
    starve_d   = '0;
    if (!fifo_empty && (win != SRC_MD)) begin
      if (starve_q == CNT_W'(STARVE_LIMIT - 1)) begin
        wb_stall_d = 1'b1;
      end else begin
        starve_d = starve_q + 1'b1;
      end
    end

    drop_err_d = drop_err_q | (bus.alu_valid & wb_stall_q);

    // Set is applied after clear so a same-cycle reissue keeps the bit.
    pending_d = pending_q;
    if (reg_write_q) pending_d[write_reg_q] = 1'b0;
    if (bus.issue_valid && (bus.issue_reg != ADDR_W'(REG_ZERO))) pending_d[bus.issue_reg] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      pending_q    <= '0;
      wb_stall_q   <= 1'b0;
      drop_err_q   <= 1'b0;
      starve_q     <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      pending_q    <= pending_d;
      wb_stall_q   <= wb_stall_d;
      drop_err_q   <= drop_err_d;
      starve_q     <= starve_d;
    end
  end

  assign bus.ld_ready   = bus.ld_valid && !bus.alu_valid && !wb_stall_q;
  assign bus.md_ready   = !fifo_full;
  assign bus.reg_write  = reg_write_q;
  assign bus.write_reg  = write_reg_q;
  assign bus.write_data = write_data_q;
  assign bus.pending    = pending_q;
  assign bus.wb_stall   = wb_stall_q;
  assign bus.drop_err   = drop_err_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed bench for regfile_writeback
module tb_regfile_writeback;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  regfile_writeback_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_writeback dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid   = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
    bus.ld_valid    = 1'b0; bus.ld_reg  = '0; bus.ld_data  = '0;
    bus.md_valid    = 1'b0; bus.md_reg  = '0; bus.md_data  = '0;
    bus.issue_valid = 1'b0; bus.issue_reg = '0;
  endtask

  // Fill the FIFO with ra/rb while the ALU holds the port for 8 cycles.
  task automatic starve_run(input logic [4:0] ra, input logic [4:0] rb, input bit alu_in_stall);
    logic [31:0] da, db;
    da = 32'hA500_0000 | 32'(ra);
    db = 32'hA500_0000 | 32'(rb);
    bus.md_valid = 1'b1; bus.md_reg = ra; bus.md_data = da;
    #1;
    chk("md_ready_empty", 64'(bus.md_ready), 64'd1);
    tick();
    for (int i = 1; i <= 8; i++) begin
      bus.alu_valid = 1'b1; bus.alu_reg = 5'd10; bus.alu_data = 32'(i);
      bus.md_valid  = (i == 1); bus.md_reg = rb; bus.md_data = db;
      #1;
      chk("no_stall_yet", 64'(bus.wb_stall), 64'd0);
      if (i == 1) chk("md_ready_one", 64'(bus.md_ready), 64'd1);
      if (i == 2) chk("md_ready_full", 64'(bus.md_ready), 64'd0);
      tick();
    end
    bus.md_valid  = 1'b0;
    bus.alu_valid = alu_in_stall; bus.alu_reg = 5'd14; bus.alu_data = 32'hEE;
    #1;
    chk("stall_high", 64'(bus.wb_stall), 64'd1);
    chk("stall_md_ready", 64'(bus.md_ready), 64'd0);
    chk("last_alu_reg", 64'(bus.write_reg), 64'd10);
    chk("last_alu_data", 64'(bus.write_data), 64'd8);
    tick();
    bus.alu_valid = 1'b0;
    #1;
    chk("stall_one_cycle", 64'(bus.wb_stall), 64'd0);
    chk("head_we", 64'(bus.reg_write), 64'd1);
    chk("head_reg", 64'(bus.write_reg), 64'(ra));
    chk("head_data", 64'(bus.write_data), 64'(da));
    chk("md_ready_freed", 64'(bus.md_ready), 64'd1);
    chk("drop_err", 64'(bus.drop_err), 64'(alu_in_stall));
    tick();
    chk("second_reg", 64'(bus.write_reg), 64'(rb));
    chk("second_data", 64'(bus.write_data), 64'(db));
    tick();
    chk("drained_we", 64'(bus.reg_write), 64'd0);
    chk("drop_err_hold", 64'(bus.drop_err), 64'(alu_in_stall));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 64'(bus.reg_write), 64'd0);
    chk("rst_reg", 64'(bus.write_reg), 64'd0);
    chk("rst_data", 64'(bus.write_data), 64'd0);
    chk("rst_pending", 64'(bus.pending), 64'd0);
    chk("rst_stall", 64'(bus.wb_stall), 64'd0);
    chk("rst_drop", 64'(bus.drop_err), 64'd0);
    chk("rst_md_ready", 64'(bus.md_ready), 64'd1);
    reset = 1'b0;
    tick();

    // ALU single write
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd3; bus.alu_data = 32'hDEADBEEF;
    tick();
    bus.alu_valid = 1'b0;
    #1;
    chk("alu_we", 64'(bus.reg_write), 64'd1);
    chk("alu_reg", 64'(bus.write_reg), 64'd3);
    chk("alu_data", 64'(bus.write_data), 64'hDEADBEEF);
    tick();
    chk("idle_we", 64'(bus.reg_write), 64'd0);
    chk("idle_hold", 64'(bus.write_data), 64'hDEADBEEF);

    // ALU beats load
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd4; bus.alu_data = 32'h1;
    bus.ld_valid  = 1'b1; bus.ld_reg  = 5'd5; bus.ld_data  = 32'h2;
    #1;
    chk("ld_blocked", 64'(bus.ld_ready), 64'd0);
    tick();
    bus.alu_valid = 1'b0;
    #1;
    chk("ld_accept", 64'(bus.ld_ready), 64'd1);
    chk("r4_reg", 64'(bus.write_reg), 64'd4);
    chk("r4_data", 64'(bus.write_data), 64'd1);
    tick();
    bus.ld_valid = 1'b0;
    #1;
    chk("r5_we", 64'(bus.reg_write), 64'd1);
    chk("r5_reg", 64'(bus.write_reg), 64'd5);
    chk("r5_data", 64'(bus.write_data), 64'd2);
    tick();

    starve_run(5'd6, 5'd7, 1'b0);
    starve_run(5'd11, 5'd13, 1'b1);

    // Scoreboard
    bus.issue_valid = 1'b1; bus.issue_reg = 5'd9;
    tick();
    bus.issue_valid = 1'b0;
    chk("pend9_set", 64'(bus.pending), 64'h200);
    tick();
    tick();
    bus.ld_valid = 1'b1; bus.ld_reg = 5'd9; bus.ld_data = 32'h99;
    #1;
    chk("ld9_ready", 64'(bus.ld_ready), 64'd1);
    tick();
    bus.ld_valid = 1'b0;
    #1;
    chk("ld9_write", 64'(bus.write_reg), 64'd9);
    chk("pend9_still", 64'(bus.pending), 64'h200);
    tick();
    chk("pend9_clear", 64'(bus.pending), 64'h0);
    bus.ld_valid = 1'b1; bus.ld_reg = 5'd9; bus.ld_data = 32'h98;
    tick();
    bus.ld_valid = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_reg = 5'd9;
    #1;
    chk("ld9b_we", 64'(bus.reg_write), 64'd1);
    tick();
    bus.issue_valid = 1'b0;
    chk("pend9_set_wins", 64'(bus.pending), 64'h200);

    // Destination zero
    bus.ld_valid = 1'b1; bus.ld_reg = 5'd0; bus.ld_data = 32'hFFFF;
    bus.issue_valid = 1'b1; bus.issue_reg = 5'd0;
    #1;
    chk("r0_ready", 64'(bus.ld_ready), 64'd1);
    tick();
    idle();
    #1;
    chk("r0_no_we", 64'(bus.reg_write), 64'd0);
    chk("r0_pending", 64'(bus.pending), 64'h200);

    // Async reset with a full FIFO
    tick();
    bus.md_valid = 1'b1; bus.md_reg = 5'd20; bus.md_data = 32'h20;
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd1; bus.alu_data = 32'h1;
    tick();
    bus.md_reg = 5'd21; bus.md_data = 32'h21;
    tick();
    idle();
    #1;
    chk("pre_rst_full", 64'(bus.md_ready), 64'd0);
    chk("pre_rst_we", 64'(bus.reg_write), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_we", 64'(bus.reg_write), 64'd0);
    chk("arst_reg", 64'(bus.write_reg), 64'd0);
    chk("arst_data", 64'(bus.write_data), 64'd0);
    chk("arst_pending", 64'(bus.pending), 64'd0);
    chk("arst_drop", 64'(bus.drop_err), 64'd0);
    chk("arst_md_ready", 64'(bus.md_ready), 64'd1);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_we", 64'(bus.reg_write), 64'd0);
    tick();
    chk("post_rst_we2", 64'(bus.reg_write), 64'd0);
    chk("post_rst_empty", 64'(bus.md_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
